instr_encoder_loader: RTL and testbench

//  Encoder side of the 9-bit machine-code format consumed by the control decoder.

---
 rtl/instr_encoder_loader_if.sv | 41 ++++
 rtl/instr_encoder_loader.sv | 181 ++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// ============================================================================
//  Module : instr_encoder_loader_if
//  Brief  : Field-beat stream, memory write port and status bundle for the
//           instruction encoder/loader.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_encoder_loader_if #(
  parameter int AW = 8
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_operand;
  logic          in_last;
  logic          mem_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;
  logic          busy;
  logic          done;
  logic          bad_op;
  logic          addr_ovf;
  logic [AW:0]   prog_len;

  // Program source / memory model side
  modport master (
    output start, in_valid, in_op, in_operand, in_last, mem_ready,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, bad_op, addr_ovf, prog_len
  );

  // Loader side
  modport slave (
    input  start, in_valid, in_op, in_operand, in_last, mem_ready,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, bad_op, addr_ovf, prog_len
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
//  Module : instr_encoder_loader
//  Brief  : Packs opcode/operand beats into 9-bit machine words, drops illegal
//           opcodes, buffers words in a small FIFO and writes them
//           sequentially into instruction memory starting at BASE_ADDR.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encoder_loader #(
  parameter int AW        = 8,
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  instr_encoder_loader_if.slave bus
);

  localparam int                c_ptr_w     = $clog2(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_ptr_w:0]  c_cnt_one   = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w:0]  c_depth     = (c_ptr_w + 1)'(DEPTH);
  localparam logic [AW-1:0]     c_base_addr = AW'(BASE_ADDR);
  localparam logic [AW-1:0]     c_addr_max  = {AW{1'b1}};
  localparam logic [AW-1:0]     c_addr_one  = AW'(1);
  localparam logic [AW:0]       c_len_max   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]       c_len_one   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [8:0]           r_fifo [DEPTH];
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [c_ptr_w:0]     r_count;

  logic [AW-1:0]        r_addr;
  logic [AW:0]          r_prog_len;
  logic                 r_addr_ovf;
  logic                 r_bad_op;

  logic                 w_busy;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_legal;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_start_load;
  logic                 w_ovf_flush;
  logic [8:0]           w_packed;

  assign w_busy       = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == c_depth);

  // Input is only open while loading; a full FIFO blocks even if a pop is due
  assign w_in_ready   = (r_state == S_LOAD) && !w_fifo_full && !r_addr_ovf;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_legal      = (bus.in_op != 4'b1000) && (bus.in_op != 4'b1011) &&
                        (bus.in_op != 4'b1100);
  assign w_push       = w_accept && w_legal;

  // Once the address space is exhausted no further writes are issued
  assign w_pop        = w_busy && !w_fifo_empty && bus.mem_ready && !r_addr_ovf;

  assign w_start_load = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_ovf_flush  = w_busy && r_addr_ovf;

  // incAddr (0111) only carries a 2-bit selector; its low operand bits are zero
  assign w_packed     = (bus.in_op == 4'b0111) ?
                        {bus.in_op, bus.in_operand[4:3], 3'b000} :
                        {bus.in_op, bus.in_operand};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: overflow aborts the load ahead of any other transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (r_addr_ovf)                  w_state_next = S_DONE;
        else if (w_accept && bus.in_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_addr_ovf || w_fifo_empty) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.start) w_state_next = S_LOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FIFO storage and pointers; flushed on a new load or after overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else if (w_start_load || w_ovf_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_packed;
        r_wptr         <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write address, program length and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst || w_start_load) begin
      r_addr     <= c_base_addr;
      r_prog_len <= '0;
      r_addr_ovf <= 1'b0;
    end else if (w_pop) begin
      r_addr <= r_addr + c_addr_one;
      if (r_addr == c_addr_max) begin
        r_addr_ovf <= 1'b1;
      end
      if (r_prog_len != c_len_max) begin
        r_prog_len <= r_prog_len + c_len_one;
      end
    end
  end

  // One-cycle pulse after an illegal opcode beat has been consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bad_op <= 1'b0;
    end else begin
      r_bad_op <= w_accept && !w_legal;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = w_pop;
  assign bus.wr_addr  = r_addr;
  assign bus.wr_data  = r_fifo[r_rptr];
  assign bus.busy     = w_busy;
  assign bus.done     = (r_state == S_DONE);
  assign bus.bad_op   = r_bad_op;
  assign bus.addr_ovf = r_addr_ovf;
  assign bus.prog_len = r_prog_len;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
//  Module : tb_instr_encoder_loader
//  Brief  : Scoreboard bench for instr_encoder_loader (AW=8 and AW=2 builds).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.AW(8)) bus8 ();
  instr_encoder_loader_if #(.AW(2)) bus2 ();

  instr_encoder_loader #(.AW(8), .DEPTH(4), .BASE_ADDR(0)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  instr_encoder_loader #(.AW(2), .DEPTH(4), .BASE_ADDR(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int          total = 0;
  int          bad   = 0;
  logic [16:0] sb8[$];
  logic [10:0] sb2[$];
  logic [16:0] e8;
  logic [10:0] e2;
  logic [7:0]  exp_addr8;
  logic [1:0]  exp_addr2;
  int          writes2;
  logic        acc2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8();
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    exp_addr8  = 8'd0;
  endtask

  // Offer one beat; push its expected write when the DUT accepts it
  task automatic send8(input logic [3:0] op, input logic [4:0] opr, input logic last,
                       input logic [8:0] expd);
    logic acc;
    acc           = 1'b0;
    bus8.in_valid = 1'b1;
    bus8.in_op    = op;
    bus8.in_operand = opr;
    bus8.in_last  = last;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (bus8.in_ready === 1'b1) begin
        acc = 1'b1;
        if (!(op == 4'd8 || op == 4'd11 || op == 4'd12)) begin
          sb8.push_back({exp_addr8, expd});
          exp_addr8 = exp_addr8 + 8'd1;
        end
      end
      tick();
    end
    bus8.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
    if (!acc) check("send8_accept", 32'(bus8.in_ready), 1);
  endtask

  task automatic wait_done8();
    int n;
    n = 0;
    while (bus8.done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("done8", 32'(bus8.done), 1);
  endtask

  // Write monitor, AW=8 build
  always @(negedge clk) begin
    if (bus8.wr_en === 1'b1) begin
      if (sb8.size() == 0) begin
        check("wr8_extra", 32'(bus8.wr_en), 0);
      end else begin
        e8 = sb8.pop_front();
        check("wr8_addr", 32'(bus8.wr_addr), 32'(e8[16:9]));
        check("wr8_data", 32'(bus8.wr_data), 32'(e8[8:0]));
      end
    end
  end

  // Write monitor, AW=2 build
  always @(negedge clk) begin
    if (bus2.wr_en === 1'b1) begin
      writes2++;
      if (sb2.size() == 0) begin
        check("wr2_extra", 32'(bus2.wr_en), 0);
      end else begin
        e2 = sb2.pop_front();
        check("wr2_addr", 32'(bus2.wr_addr), 32'(e2[10:9]));
        check("wr2_data", 32'(bus2.wr_data), 32'(e2[8:0]));
      end
    end
  end

  // Hard stop in case the sequence wedges somewhere unbounded
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.in_valid = 1'b0; bus8.in_op = '0; bus8.in_operand = '0;
    bus8.in_last = 1'b0; bus8.mem_ready = 1'b0;
    bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.in_op = '0; bus2.in_operand = '0;
    bus2.in_last = 1'b0; bus2.mem_ready = 1'b0;
    exp_addr8 = '0; exp_addr2 = '0; writes2 = 0; acc2 = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_in_ready", 32'(bus8.in_ready), 0);
    check("rst_wr_en",    32'(bus8.wr_en),    0);
    check("rst_busy",     32'(bus8.busy),     0);
    check("rst_done",     32'(bus8.done),     0);
    check("rst_bad_op",   32'(bus8.bad_op),   0);
    check("rst_addr_ovf", 32'(bus8.addr_ovf), 0);
    check("rst_prog_len", 32'(bus8.prog_len), 0);
    check("rst_wr_addr",  32'(bus8.wr_addr),  0);
    check("rst_wr_data",  32'(bus8.wr_data),  0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(bus8.in_ready), 0);

    // T1: three legal beats, memory always ready
    bus8.mem_ready = 1'b1;
    start8();
    check("t1_busy", 32'(bus8.busy), 1);
    send8(4'b0000, 5'b00101, 1'b0, 9'h005);
    send8(4'b1101, 5'b00010, 1'b0, 9'h1A2);
    send8(4'b1110, 5'b00011, 1'b1, 9'h1C3);
    wait_done8();
    check("t1_prog_len", 32'(bus8.prog_len), 3);
    check("t1_busy_done", 32'(bus8.busy), 0);
    check("t1_in_ready", 32'(bus8.in_ready), 0);
    check("t1_sb_left", 32'(sb8.size()), 0);

    // T2: incAddr packing and single-cycle latency
    start8();
    send8(4'b0111, 5'b11111, 1'b1, 9'h0F8);
    @(negedge clk);
    check("t2_latency", 32'(bus8.wr_en), 1);
    tick();
    wait_done8();
    check("t2_prog_len", 32'(bus8.prog_len), 1);

    // T3: illegal opcode between two legal beats
    start8();
    send8(4'b0001, 5'b00011, 1'b0, 9'h023);
    @(negedge clk);
    check("t3_no_bad_op", 32'(bus8.bad_op), 0);
    tick();
    send8(4'b1011, 5'b00100, 1'b0, 9'h000);
    @(negedge clk);
    check("t3_bad_op", 32'(bus8.bad_op), 1);
    tick();
    check("t3_bad_op_clr", 32'(bus8.bad_op), 0);
    send8(4'b0010, 5'b00001, 1'b1, 9'h041);
    wait_done8();
    check("t3_prog_len", 32'(bus8.prog_len), 2);

    // T4: memory stalled while five beats are offered
    bus8.mem_ready = 1'b0;
    start8();
    send8(4'b0000, 5'b00001, 1'b0, 9'h001);
    send8(4'b0011, 5'b00010, 1'b0, 9'h062);
    send8(4'b0101, 5'b11111, 1'b0, 9'h0BF);
    send8(4'b1001, 5'b00000, 1'b0, 9'h120);
    bus8.in_valid = 1'b1; bus8.in_op = 4'b1111; bus8.in_operand = 5'b10101; bus8.in_last = 1'b1;
    @(negedge clk);
    check("t4_full_ready", 32'(bus8.in_ready), 0);
    check("t4_stall_wr",   32'(bus8.wr_en),    0);
    tick();
    @(negedge clk);
    check("t4_hold_ready", 32'(bus8.in_ready), 0);
    check("t4_hold_addr",  32'(bus8.wr_addr),  0);
    tick();
    bus8.mem_ready = 1'b1;
    send8(4'b1111, 5'b10101, 1'b1, 9'h1F5);
    wait_done8();
    check("t4_prog_len", 32'(bus8.prog_len), 5);

    // T6: reset while draining with two words queued
    bus8.mem_ready = 1'b0;
    start8();
    send8(4'b0100, 5'b00110, 1'b0, 9'h086);
    send8(4'b0110, 5'b00001, 1'b1, 9'h0C1);
    tick();
    check("t6_drain_busy", 32'(bus8.busy), 1);
    check("t6_drain_done", 32'(bus8.done), 0);
    rst = 1'b1;
    tick();
    bus8.mem_ready = 1'b1;
    sb8.delete();
    @(negedge clk);
    check("t6_wr_en",     32'(bus8.wr_en),    0);
    check("t6_busy",      32'(bus8.busy),     0);
    check("t6_done",      32'(bus8.done),     0);
    check("t6_prog_len",  32'(bus8.prog_len), 0);
    tick();
    rst = 1'b0;
    start8();
    send8(4'b0011, 5'b00111, 1'b1, 9'h067);
    wait_done8();
    check("t6_restart_len", 32'(bus8.prog_len), 1);

    // T5: AW=2 build, six beats without last run off the end of memory
    bus2.mem_ready = 1'b1;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    exp_addr2 = 2'd0;
    writes2 = 0;
    for (int b = 0; b < 6; b++) begin
      bus2.in_valid   = 1'b1;
      bus2.in_op      = 4'(b + 1);
      bus2.in_operand = 5'(b);
      bus2.in_last    = 1'b0;
      acc2 = 1'b0;
      for (int n = 0; n < 20 && !acc2 && (bus2.done !== 1'b1); n++) begin
        @(negedge clk);
        if (bus2.in_ready === 1'b1) begin
          acc2 = 1'b1;
          sb2.push_back({exp_addr2, 4'(b + 1), 5'(b)});
          exp_addr2 = exp_addr2 + 2'd1;
        end
        tick();
      end
      bus2.in_valid = 1'b0;
    end
    repeat (3) tick();
    check("t5_writes",   32'(writes2),        4);
    check("t5_addr_ovf", 32'(bus2.addr_ovf),  1);
    check("t5_done",     32'(bus2.done),      1);
    check("t5_prog_len", 32'(bus2.prog_len),  4);
    check("t5_in_ready", 32'(bus2.in_ready),  0);
    check("t5_wr_en",    32'(bus2.wr_en),     0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
